lock_keypad_sender: RTL and testbench

LOCK_KEYPAD_SENDER -- requirements
Module: lock_keypad_sender

---
 rtl/lock_pkg.sv | 23 ++
 rtl/digit_buffer.sv | 39 +++
 rtl/lock_keypad_sender.sv | 168 ++++++++++++++++
 tb/tb_lock_keypad_sender.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad sender and the lock it talks to:
// state codes, code length and mode values.
package lock_pkg;

  localparam int DIGITS = 4;

  localparam logic [1:0] MODE_SET = 2'd0;
  localparam logic [1:0] MODE_VAL = 2'd1;

  typedef logic [2:0] lock_state_t;

  localparam lock_state_t ST_IDLE  = 3'd0;
  localparam lock_state_t ST_START = 3'd1;
  localparam lock_state_t ST_SEND  = 3'd2;
  localparam lock_state_t ST_WAIT  = 3'd3;
  localparam lock_state_t ST_DONE  = 3'd4;

  // Modes 2 and 3 are reserved and never forwarded to the lock.
  function automatic logic mode_is_valid(input logic [1:0] mode);
    return (mode == MODE_SET) || (mode == MODE_VAL);
  endfunction

endpackage

// File: rtl/digit_buffer.sv
// Four-entry digit store with fill count, append/clear control and an
// indexed read port used while the code is being transmitted.
module digit_buffer
  import lock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [3:0] wr_data,
  input  logic [1:0] rd_idx,
  output logic [3:0] rd_data,
  output logic [2:0] count,
  output logic       full
);

  logic [3:0] mem_r [DIGITS];
  logic [2:0] count_r;

  // Storage and fill count; a clear only rewinds the count, contents are wiped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        mem_r[i] <= 4'd0;
      end
      count_r <= 3'd0;
    end else if (clr) begin
      count_r <= 3'd0;
    end else if (wr_en && (count_r < 3'(DIGITS))) begin
      mem_r[count_r[1:0]] <= wr_data;
      count_r             <= count_r + 3'd1;
    end
  end

  assign rd_data = mem_r[rd_idx];
  assign count   = count_r;
  assign full    = (count_r == 3'(DIGITS));

endmodule

// File: rtl/lock_keypad_sender.sv
// Collects a four-digit code from a keypad and forwards it to the lock,
// then reports the lock's verdict (unlock, error or timeout) as one pulse.
module lock_keypad_sender
  import lock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_clear,
  input  logic       key_enter,
  input  logic [1:0] mode_sel,
  output logic       lock_start,
  output logic [1:0] lock_mode,
  output logic       lock_step,
  output logic [3:0] lock_code,
  input  logic       lock_unlock,
  input  logic       lock_err,
  input  logic       lock_alert,
  output logic       busy,
  output logic [2:0] count,
  output logic       result_ok,
  output logic       result_fail,
  output logic       result_timeout,
  output logic       alert_seen
);

  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

  lock_state_t       state_r;
  lock_state_t       state_nxt_s;
  logic [2:0]        send_cnt_r;
  logic [WCNT_W-1:0] wait_cnt_r;

  logic       enter_ok_s;
  logic       emit_s;
  logic       resp_s;
  logic       buf_clr_s;
  logic       buf_wr_s;
  logic       buf_full_s;
  logic [3:0] rd_data_s;

  logic       lock_start_r;
  logic [1:0] lock_mode_r;
  logic       lock_step_r;
  logic [3:0] lock_code_r;
  logic       busy_r;
  logic       result_ok_r;
  logic       result_fail_r;
  logic       result_timeout_r;
  logic       alert_seen_r;

  digit_buffer u_digit_buffer (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr_s),
    .wr_en   (buf_wr_s),
    .wr_data (key_code),
    .rd_idx  (send_cnt_r[1:0]),
    .rd_data (rd_data_s),
    .count   (count),
    .full    (buf_full_s)
  );

  // Next-state decode plus the buffer and transmit controls derived from it.
  always_comb begin
    state_nxt_s = state_r;
    enter_ok_s  = 1'b0;
    emit_s      = 1'b0;
    buf_clr_s   = 1'b0;
    buf_wr_s    = 1'b0;
    resp_s      = lock_unlock | lock_err;
    case (state_r)
      ST_IDLE: begin
        if (key_clear) begin
          buf_clr_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          buf_wr_s = key_valid & ~buf_full_s;
          if (key_enter && buf_full_s && mode_is_valid(mode_sel)) begin
            enter_ok_s  = 1'b1;
            state_nxt_s = ST_START;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
      end
      ST_START: begin
        emit_s      = 1'b1;
        state_nxt_s = ST_SEND;
      end
      ST_SEND: begin
        // The last digit is still on the wire while send_cnt_r reads DIGITS.
        if (send_cnt_r == 3'(DIGITS)) begin
          state_nxt_s = ST_WAIT;
        end else begin
          emit_s      = 1'b1;
          state_nxt_s = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (resp_s || (wait_cnt_r == WAIT_LAST)) begin
          buf_clr_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        buf_clr_s   = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      send_cnt_r       <= 3'd0;
      wait_cnt_r       <= '0;
      lock_start_r     <= 1'b0;
      lock_mode_r      <= 2'd0;
      lock_step_r      <= 1'b0;
      lock_code_r      <= 4'd0;
      busy_r           <= 1'b0;
      result_ok_r      <= 1'b0;
      result_fail_r    <= 1'b0;
      result_timeout_r <= 1'b0;
      alert_seen_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (enter_ok_s) begin
        send_cnt_r <= 3'd0;
      end else if (emit_s) begin
        send_cnt_r <= send_cnt_r + 3'd1;
      end
      wait_cnt_r <= (state_r == ST_WAIT) ? (wait_cnt_r + WCNT_W'(1)) : '0;
      // The latched mode lives only for the START cycle, which is when the lock samples it.
      lock_start_r     <= enter_ok_s;
      lock_mode_r      <= enter_ok_s ? mode_sel : 2'd0;
      lock_step_r      <= emit_s;
      lock_code_r      <= emit_s ? rd_data_s : 4'd0;
      busy_r           <= (state_nxt_s != ST_IDLE);
      result_ok_r      <= (state_r == ST_WAIT) && lock_unlock;
      result_fail_r    <= (state_r == ST_WAIT) && !lock_unlock && lock_err;
      result_timeout_r <= (state_r == ST_WAIT) && !resp_s && (wait_cnt_r == WAIT_LAST);
      alert_seen_r     <= lock_alert;
    end
  end

  assign lock_start     = lock_start_r;
  assign lock_mode      = lock_mode_r;
  assign lock_step      = lock_step_r;
  assign lock_code      = lock_code_r;
  assign busy           = busy_r;
  assign result_ok      = result_ok_r;
  assign result_fail    = result_fail_r;
  assign result_timeout = result_timeout_r;
  assign alert_seen     = alert_seen_r;

endmodule

// File: tb/tb_lock_keypad_sender.sv
// Self-checking bench: keypad table vectors, directed transactions and
// randomized sessions against a queue-based model with timing rules.
module tb_lock_keypad_sender;

  localparam int TO = 16;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_clear;
  logic       key_enter;
  logic [1:0] mode_sel;
  logic       lock_start;
  logic [1:0] lock_mode;
  logic       lock_step;
  logic [3:0] lock_code;
  logic       lock_unlock;
  logic       lock_err;
  logic       lock_alert;
  logic       busy;
  logic [2:0] count;
  logic       result_ok;
  logic       result_fail;
  logic       result_timeout;
  logic       alert_seen;

  int checks;
  int failures;
  logic [3:0] q[$];

  typedef struct packed {
    logic       v;
    logic [3:0] code;
    logic       clr;
    logic       ent;
    logic [1:0] mode;
    logic [2:0] exp_cnt;
    logic       exp_busy;
    logic       exp_start;
  } vec_t;

  vec_t tbl[14];

  lock_keypad_sender #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_clear      (key_clear),
    .key_enter      (key_enter),
    .mode_sel       (mode_sel),
    .lock_start     (lock_start),
    .lock_mode      (lock_mode),
    .lock_step      (lock_step),
    .lock_code      (lock_code),
    .lock_unlock    (lock_unlock),
    .lock_err       (lock_err),
    .lock_alert     (lock_alert),
    .busy           (busy),
    .count          (count),
    .result_ok      (result_ok),
    .result_fail    (result_fail),
    .result_timeout (result_timeout),
    .alert_seen     (alert_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    key_valid   = 1'b0;
    key_code    = 4'd0;
    key_clear   = 1'b0;
    key_enter   = 1'b0;
    mode_sel    = 2'd0;
    lock_unlock = 1'b0;
    lock_err    = 1'b0;
    lock_alert  = 1'b0;
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    step();
    key_valid = 1'b0;
    if (q.size() < 4) q.push_back(c);
    chk("press_count", 32'(count), 32'(q.size()));
  endtask

  // kind: 0 unlock, 1 err, 2 unlock+err, 3 no response. dly = WAIT cycle index of the response.
  task automatic run_txn(input logic [15:0] digs, input logic [1:0] mode,
                         input int kind, input int dly, input bit noise);
    int res_c;
    res_c = (kind == 3) ? (6 + TO) : (7 + dly);
    key_enter = 1'b1;
    mode_sel  = mode;
    step();
    clear_inputs();
    for (int c = 1; c <= res_c + 1; c++) begin
      chk("start",   32'(lock_start),     32'(c == 1));
      chk("mode",    32'(lock_mode),      (c == 1) ? 32'(mode) : 32'd0);
      chk("step",    32'(lock_step),      32'(c >= 2 && c <= 5));
      chk("code",    32'(lock_code),      (c >= 2 && c <= 5) ? 32'(digs[4*(c-2) +: 4]) : 32'd0);
      chk("busy",    32'(busy),           32'(c <= res_c));
      chk("ok",      32'(result_ok),      32'(c == res_c && (kind == 0 || kind == 2)));
      chk("fail",    32'(result_fail),    32'(c == res_c && kind == 1));
      chk("timeout", 32'(result_timeout), 32'(c == res_c && kind == 3));
      if (c < res_c) chk("count_busy", 32'(count), 32'd4);
      if (c == res_c + 1) chk("count_after", 32'(count), 32'd0);
      if (c <= res_c) begin
        lock_unlock = (kind == 0 || kind == 2) && (c == 6 + dly);
        lock_err    = (kind == 1 || kind == 2) && (c == 6 + dly);
        if (noise) begin
          key_valid = 1'($urandom_range(0, 1));
          key_code  = 4'($urandom_range(0, 15));
          key_clear = ($urandom_range(0, 3) == 0);
          key_enter = 1'($urandom_range(0, 1));
          mode_sel  = 2'($urandom_range(0, 3));
        end
        step();
      end
    end
    clear_inputs();
  endtask

  task automatic idle_random_ops(input int n);
    int r;
    logic [3:0] c;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      c = 4'($urandom_range(0, 15));
      key_code = c;
      if (r <= 5) key_valid = 1'b1;
      if (r == 6 || r == 7) key_clear = 1'b1;
      if (r == 7) key_valid = 1'b1;
      if (r == 8) begin
        key_enter = 1'b1;
        mode_sel  = 2'($urandom_range(2, 3));
      end
      if (r == 9 && q.size() < 4) begin
        key_enter = 1'b1;
        mode_sel  = 2'($urandom_range(0, 1));
      end
      step();
      if (key_clear) q.delete();
      else if (key_valid && q.size() < 4) q.push_back(c);
      clear_inputs();
      chk("rnd_count", 32'(count), 32'(q.size()));
      chk("rnd_busy",  32'(busy), 32'd0);
      chk("rnd_start", 32'(lock_start), 32'd0);
    end
  endtask

  task automatic fill_and_send(input logic [1:0] mode, input int kind, input int dly, input bit noise);
    logic [15:0] digs;
    while (q.size() < 4) press(4'($urandom_range(0, 15)));
    digs = {q[3], q[2], q[1], q[0]};
    run_txn(digs, mode, kind, dly, noise);
    q.delete();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_start", 32'(lock_start), 32'd0);
    chk("rst_mode",  32'(lock_mode), 32'd0);
    chk("rst_step",  32'(lock_step), 32'd0);
    chk("rst_code",  32'(lock_code), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_res",   32'({result_ok, result_fail, result_timeout}), 32'd0);
    chk("rst_alert", 32'(alert_seen), 32'd0);
    rst = 1'b0;

    //             v     code   clr   ent   mode  cnt   busy  start
    tbl[0]  = '{1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 3'd1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'd3, 1'b0, 1'b0, 2'd0, 3'd3, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'd0, 1'b0, 1'b1, 2'd1, 3'd3, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'd4, 1'b0, 1'b0, 2'd0, 3'd4, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'd5, 1'b0, 1'b0, 2'd0, 3'd4, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'd0, 1'b0, 1'b1, 2'd2, 3'd4, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'd0, 1'b0, 1'b1, 2'd3, 3'd4, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'd0, 1'b1, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'd6, 1'b0, 1'b0, 2'd0, 3'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'd7, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'd8, 1'b0, 1'b0, 2'd0, 3'd1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'd9, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      key_valid = tbl[i].v;
      key_code  = tbl[i].code;
      key_clear = tbl[i].clr;
      key_enter = tbl[i].ent;
      mode_sel  = tbl[i].mode;
      step();
      clear_inputs();
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_busy", i),  32'(busy), 32'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_start", i), 32'(lock_start), 32'(tbl[i].exp_start));
    end
    q.delete();

    // Keys 1..4, validate mode, unlock in the second WAIT cycle.
    for (int k = 1; k <= 4; k++) press(4'(k));
    fill_and_send(2'd1, 0, 1, 1'b0);
    // 9,9,9,9 with err in the first WAIT cycle.
    for (int k = 0; k < 4; k++) press(4'd9);
    fill_and_send(2'd0, 1, 0, 1'b0);
    // No response at all.
    for (int k = 0; k < 4; k++) press(4'(k + 10));
    fill_and_send(2'd1, 3, 0, 1'b0);
    // Five keys: the fifth is dropped; unlock and err together resolve as ok.
    for (int k = 1; k <= 5; k++) press(4'(k));
    fill_and_send(2'd0, 2, 3, 1'b1);
    // Response in the last allowed WAIT cycle still beats the timeout.
    fill_and_send(2'd1, 0, TO - 1, 1'b1);

    // Reset in the middle of SEND.
    for (int k = 0; k < 4; k++) press(4'(k + 3));
    key_enter = 1'b1;
    mode_sel  = 2'd1;
    step();
    clear_inputs();
    chk("mid_start", 32'(lock_start), 32'd1);
    step();
    step();
    chk("mid_step", 32'(lock_step), 32'd1);
    chk("mid_code", 32'(lock_code), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    chk("mid_rst_step",  32'(lock_step), 32'd0);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    for (int i = 0; i < 24; i++) begin
      step();
      chk("post_rst_res",  32'({result_ok, result_fail, result_timeout}), 32'd0);
      chk("post_rst_step", 32'(lock_step), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    // Alert is a plain one-cycle delay.
    lock_alert = 1'b1;
    step();
    chk("alert_hi", 32'(alert_seen), 32'd1);
    lock_alert = 1'b0;
    step();
    chk("alert_lo", 32'(alert_seen), 32'd0);

    for (int t = 0; t < 25; t++) begin
      idle_random_ops(int'($urandom_range(3, 10)));
      fill_and_send(2'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, TO - 1)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
